// File: rtl/cmac_usplus_0_axis_pkt_mon.sv
// Receive-side AXI4-Stream packet monitor for the CMAC example design.
// Checks length, keep encoding, MAC error flag and payload of every frame, and keeps counters.
module cmac_usplus_0_axis_pkt_mon #(
    parameter int unsigned PKT_NUM  = 1000,
    parameter int unsigned PKT_SIZE = 522,
    parameter logic [23:0] TIMEOUT  = 24'hFFFFFF
) (
    input  logic         aclk,
    input  logic         aresetn,
    input  logic         rx_axis_tvalid,
    input  logic [511:0] rx_axis_tdata,
    input  logic [63:0]  rx_axis_tkeep,
    input  logic         rx_axis_tlast,
    input  logic         rx_axis_tuser,
    input  logic         stat_rx_aligned,
    input  logic         lbus_tx_rx_restart_in,
    output logic         ctl_rx_enable,
    output logic [15:0]  pkt_ok_cnt,
    output logic [15:0]  pkt_err_cnt,
    output logic [31:0]  byte_cnt,
    output logic         rx_aligned_led,
    output logic         rx_busy_led,
    output logic         rx_done_led,
    output logic         rx_fail_led
);

    localparam logic [13:0] PktSize = 14'(PKT_SIZE);
    localparam logic [16:0] PktNum  = 17'(PKT_NUM);

    typedef enum logic [1:0] {StIdle, StWaitAlign, StRecv, StDone} state_e;

    state_e      state;
    logic        restart_q1;
    logic        restart_q2;
    logic        restart;
    logic [13:0] len_q;
    logic [7:0]  seq_q;
    logic        err_q;
    logic        in_frame_q;
    logic [23:0] idle_q;

    logic        keep_full;
    logic        keep_therm;
    logic        payload_err;
    logic        beat_err;
    logic [6:0]  keep_ones;
    logic [13:0] frame_len;
    logic        frame_bad;
    logic [16:0] pkt_total;
    logic [32:0] byte_sum;

    assign restart = restart_q1 & ~restart_q2;

    // len_q[7:6] is the beat index modulo 4, i.e. bits [7:6] of the frame byte offset.
    always_comb begin
        keep_ones   = '0;
        payload_err = 1'b0;
        for (int k = 0; k < 64; k++) begin
            keep_ones = keep_ones + 7'(rx_axis_tkeep[k]);
            if (rx_axis_tkeep[k] &&
                (rx_axis_tdata[8*k +: 8] != ({len_q[7:6], 6'(k)} ^ seq_q))) begin
                payload_err = 1'b1;
            end
        end
    end

    assign keep_full  = &rx_axis_tkeep;
    assign keep_therm = rx_axis_tkeep[0] &&
                        ((rx_axis_tkeep & (rx_axis_tkeep + 64'd1)) == 64'd0);
    assign beat_err   = payload_err |
                        (rx_axis_tlast ? (~keep_therm | rx_axis_tuser) : ~keep_full);
    assign frame_len  = len_q + 14'(keep_ones);
    assign frame_bad  = err_q | beat_err | (frame_len != PktSize);
    assign pkt_total  = {1'b0, pkt_ok_cnt} + {1'b0, pkt_err_cnt};
    assign byte_sum   = {1'b0, byte_cnt} + 33'(frame_len);

    assign rx_busy_led = (state == StRecv);
    assign rx_done_led = (state == StDone);

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state          <= StIdle;
            ctl_rx_enable  <= 1'b0;
            pkt_ok_cnt     <= '0;
            pkt_err_cnt    <= '0;
            byte_cnt       <= '0;
            rx_aligned_led <= 1'b0;
            rx_fail_led    <= 1'b0;
            restart_q1     <= 1'b0;
            restart_q2     <= 1'b0;
            len_q          <= '0;
            seq_q          <= '0;
            err_q          <= 1'b0;
            in_frame_q     <= 1'b0;
            idle_q         <= '0;
        end else begin
            restart_q1     <= lbus_tx_rx_restart_in;
            restart_q2     <= restart_q1;
            rx_aligned_led <= stat_rx_aligned;
            if (restart) begin
                state         <= StWaitAlign;
                ctl_rx_enable <= 1'b1;
                pkt_ok_cnt    <= '0;
                pkt_err_cnt   <= '0;
                byte_cnt      <= '0;
                rx_fail_led   <= 1'b0;
                len_q         <= '0;
                seq_q         <= '0;
                err_q         <= 1'b0;
                in_frame_q    <= 1'b0;
                idle_q        <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        state         <= StWaitAlign;
                        ctl_rx_enable <= 1'b1;
                    end
                    StWaitAlign: begin
                        idle_q <= '0;
                        if (stat_rx_aligned) begin
                            state <= StRecv;
                        end
                    end
                    StRecv: begin
                        if (rx_axis_tvalid) begin
                            idle_q <= '0;
                            if (rx_axis_tlast) begin
                                if (frame_bad) begin
                                    if (pkt_err_cnt != 16'hFFFF) begin
                                        pkt_err_cnt <= pkt_err_cnt + 16'd1;
                                    end
                                    rx_fail_led <= 1'b1;
                                end else begin
                                    if (pkt_ok_cnt != 16'hFFFF) begin
                                        pkt_ok_cnt <= pkt_ok_cnt + 16'd1;
                                    end
                                    byte_cnt <= byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
                                end
                                seq_q      <= seq_q + 8'd1;
                                len_q      <= '0;
                                err_q      <= 1'b0;
                                in_frame_q <= 1'b0;
                            end else begin
                                len_q      <= len_q + 14'd64;
                                err_q      <= err_q | beat_err;
                                in_frame_q <= 1'b1;
                            end
                        end else begin
                            idle_q <= idle_q + 24'd1;
                        end

                        if (!stat_rx_aligned) begin
                            state       <= StWaitAlign;
                            rx_fail_led <= 1'b1;
                            // A tlast in this cycle was already counted above.
                            if (!(rx_axis_tvalid && rx_axis_tlast) &&
                                (in_frame_q || rx_axis_tvalid)) begin
                                if (pkt_err_cnt != 16'hFFFF) begin
                                    pkt_err_cnt <= pkt_err_cnt + 16'd1;
                                end
                                seq_q      <= seq_q + 8'd1;
                                len_q      <= '0;
                                err_q      <= 1'b0;
                                in_frame_q <= 1'b0;
                            end
                        end else if (!rx_axis_tvalid && (idle_q == TIMEOUT - 24'd1)) begin
                            rx_fail_led <= 1'b1;
                            state       <= StDone;
                        end else if (pkt_total >= PktNum) begin
                            state <= StDone;
                        end
                    end
                    StDone: begin
                        state <= StDone;
                    end
                    default: begin
                        state <= StIdle;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cmac_usplus_0_axis_pkt_mon.sv
// Directed bench for the CMAC RX packet monitor: good runs, bad frames, alignment loss,
// timeout, restart and mid-frame reset.
module tb_cmac_usplus_0_axis_pkt_mon;

    localparam int unsigned PKT_NUM  = 1000;
    localparam int unsigned PKT_SIZE = 522;
    localparam logic [23:0] TIMEOUT  = 24'd100;

    logic         aclk;
    logic         aresetn;
    logic         rx_axis_tvalid;
    logic [511:0] rx_axis_tdata;
    logic [63:0]  rx_axis_tkeep;
    logic         rx_axis_tlast;
    logic         rx_axis_tuser;
    logic         stat_rx_aligned;
    logic         lbus_tx_rx_restart_in;
    logic         ctl_rx_enable;
    logic [15:0]  pkt_ok_cnt;
    logic [15:0]  pkt_err_cnt;
    logic [31:0]  byte_cnt;
    logic         rx_aligned_led;
    logic         rx_busy_led;
    logic         rx_done_led;
    logic         rx_fail_led;

    int checks = 0;
    int errors = 0;

    cmac_usplus_0_axis_pkt_mon #(
        .PKT_NUM  (PKT_NUM),
        .PKT_SIZE (PKT_SIZE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .aclk                  (aclk),
        .aresetn               (aresetn),
        .rx_axis_tvalid        (rx_axis_tvalid),
        .rx_axis_tdata         (rx_axis_tdata),
        .rx_axis_tkeep         (rx_axis_tkeep),
        .rx_axis_tlast         (rx_axis_tlast),
        .rx_axis_tuser         (rx_axis_tuser),
        .stat_rx_aligned       (stat_rx_aligned),
        .lbus_tx_rx_restart_in (lbus_tx_rx_restart_in),
        .ctl_rx_enable         (ctl_rx_enable),
        .pkt_ok_cnt            (pkt_ok_cnt),
        .pkt_err_cnt           (pkt_err_cnt),
        .byte_cnt              (byte_cnt),
        .rx_aligned_led        (rx_aligned_led),
        .rx_busy_led           (rx_busy_led),
        .rx_done_led           (rx_done_led),
        .rx_fail_led           (rx_fail_led)
    );

    initial begin
        aclk = 1'b0;
        forever #5 aclk = ~aclk;
    end

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic idle_bus();
        rx_axis_tvalid = 1'b0;
        rx_axis_tdata  = '0;
        rx_axis_tkeep  = '0;
        rx_axis_tlast  = 1'b0;
        rx_axis_tuser  = 1'b0;
    endtask

    // Drives one beat for one cycle; byte n carries n[7:0]^seq, inverted at offset corrupt.
    task automatic drive_beat(input logic [7:0] seq, input int beat, input logic [63:0] keep,
                              input logic last, input logic user, input int corrupt);
        logic [7:0] b;
        int n;
        for (int k = 0; k < 64; k++) begin
            n = beat * 64 + k;
            b = 8'(n) ^ seq;
            if (n == corrupt) b = ~b;
            rx_axis_tdata[8*k +: 8] = b;
        end
        rx_axis_tvalid = 1'b1;
        rx_axis_tkeep  = keep;
        rx_axis_tlast  = last;
        rx_axis_tuser  = user;
        step();
    endtask

    task automatic send_frame(input logic [7:0] seq, input int len, input logic [63:0] keep_ovr,
                              input logic user, input int corrupt);
        int beats;
        int m;
        logic [63:0] last_keep;
        beats = (len + 63) / 64;
        m = len - 64 * (beats - 1);
        for (int b = 0; b < beats - 1; b++) drive_beat(seq, b, '1, 1'b0, 1'b0, corrupt);
        last_keep = (m == 64) ? '1 : ((64'd1 << m) - 64'd1);
        if (keep_ovr != 64'd0) last_keep = keep_ovr;
        drive_beat(seq, beats - 1, last_keep, 1'b1, user, corrupt);
        idle_bus();
    endtask

    task automatic do_restart();
        lbus_tx_rx_restart_in = 1'b1;
        step();
        step();
        step();
        lbus_tx_rx_restart_in = 1'b0;
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        stat_rx_aligned = 1'b0;
        lbus_tx_rx_restart_in = 1'b0;
        idle_bus();
        step();
        step();
        checks++;
        if (ctl_rx_enable !== 1'b0) begin
            errors++; $display("FAIL reset_ctl got %b want 0", ctl_rx_enable);
        end
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt, byte_cnt} !== 64'd0) begin
            errors++; $display("FAIL reset_cnt got %0d/%0d/%0d want 0/0/0",
                               pkt_ok_cnt, pkt_err_cnt, byte_cnt);
        end
        checks++;
        if ({rx_aligned_led, rx_busy_led, rx_done_led, rx_fail_led} !== 4'b0000) begin
            errors++; $display("FAIL reset_leds got %b want 0000",
                               {rx_aligned_led, rx_busy_led, rx_done_led, rx_fail_led});
        end
        aresetn = 1'b1;
        step();
        checks++;
        if ({ctl_rx_enable, rx_busy_led} !== 2'b10) begin
            errors++; $display("FAIL release_ctl_busy got %b want 10",
                               {ctl_rx_enable, rx_busy_led});
        end
    endtask

    task automatic test_align();
        stat_rx_aligned = 1'b1;
        step();
        checks++;
        if ({rx_aligned_led, rx_busy_led} !== 2'b11) begin
            errors++; $display("FAIL align_led_busy got %b want 11",
                               {rx_aligned_led, rx_busy_led});
        end
    endtask

    // corrupt_frame < 0 gives an all-good run.
    task automatic test_full_run(input int corrupt_frame);
        int ok_want;
        int err_want;
        ok_want  = (corrupt_frame < 0) ? 1000 : 999;
        err_want = (corrupt_frame < 0) ? 0 : 1;
        for (int i = 0; i < 1000; i++) begin
            send_frame(8'(i), 522, 64'd0, 1'b0, (i == corrupt_frame) ? 100 : -1);
            if (i == 0) begin
                checks++;
                if ({pkt_ok_cnt, byte_cnt} !== {16'd1, 32'd522}) begin
                    errors++; $display("FAIL run_first got ok=%0d bytes=%0d want 1/522",
                                       pkt_ok_cnt, byte_cnt);
                end
            end
            if (i == corrupt_frame) begin
                checks++;
                if ({pkt_ok_cnt, pkt_err_cnt, rx_fail_led} !== {16'd5, 16'd1, 1'b1}) begin
                    errors++; $display("FAIL corrupt_frame got ok=%0d err=%0d fail=%b want 5/1/1",
                                       pkt_ok_cnt, pkt_err_cnt, rx_fail_led);
                end
            end
        end
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt} !== {16'(ok_want), 16'(err_want)}) begin
            errors++; $display("FAIL run_counts got ok=%0d err=%0d want %0d/%0d",
                               pkt_ok_cnt, pkt_err_cnt, ok_want, err_want);
        end
        checks++;
        if (byte_cnt !== 32'(ok_want * 522)) begin
            errors++; $display("FAIL run_bytes got %0d want %0d", byte_cnt, ok_want * 522);
        end
        checks++;
        if (rx_done_led !== 1'b0) begin
            errors++; $display("FAIL run_done_early got %b want 0", rx_done_led);
        end
        step();
        checks++;
        if ({rx_done_led, rx_busy_led, rx_fail_led} !== {2'b10, (corrupt_frame >= 0)}) begin
            errors++; $display("FAIL run_done got done/busy/fail=%b want %b",
                               {rx_done_led, rx_busy_led, rx_fail_led},
                               {2'b10, (corrupt_frame >= 0)});
        end
    endtask

    task automatic test_restart();
        do_restart();
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt, byte_cnt} !== 64'd0) begin
            errors++; $display("FAIL restart_cnt got %0d/%0d/%0d want 0/0/0",
                               pkt_ok_cnt, pkt_err_cnt, byte_cnt);
        end
        checks++;
        if ({rx_done_led, rx_fail_led, rx_busy_led} !== 3'b001) begin
            errors++; $display("FAIL restart_leds got done/fail/busy=%b want 001",
                               {rx_done_led, rx_fail_led, rx_busy_led});
        end
    endtask

    task automatic test_bad_frames();
        send_frame(8'd0, 521, 64'd0, 1'b0, -1);
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt} !== {16'd0, 16'd1}) begin
            errors++; $display("FAIL short_frame got ok=%0d err=%0d want 0/1",
                               pkt_ok_cnt, pkt_err_cnt);
        end
        send_frame(8'd1, 522, 64'd0, 1'b1, -1);
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt} !== {16'd0, 16'd2}) begin
            errors++; $display("FAIL tuser_frame got ok=%0d err=%0d want 0/2",
                               pkt_ok_cnt, pkt_err_cnt);
        end
        send_frame(8'd2, 522, 64'h3FD, 1'b0, -1);
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt} !== {16'd0, 16'd3}) begin
            errors++; $display("FAIL keep_frame got ok=%0d err=%0d want 0/3",
                               pkt_ok_cnt, pkt_err_cnt);
        end
        send_frame(8'd3, 522, 64'd0, 1'b0, -1);
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt, byte_cnt, rx_fail_led} !==
            {16'd1, 16'd3, 32'd522, 1'b1}) begin
            errors++; $display("FAIL after_bad got ok=%0d err=%0d bytes=%0d fail=%b want 1/3/522/1",
                               pkt_ok_cnt, pkt_err_cnt, byte_cnt, rx_fail_led);
        end
    endtask

    task automatic test_align_loss();
        for (int b = 0; b < 4; b++) drive_beat(8'd4, b, '1, 1'b0, 1'b0, -1);
        stat_rx_aligned = 1'b0;
        drive_beat(8'd4, 4, '1, 1'b0, 1'b0, -1);
        idle_bus();
        checks++;
        if ({pkt_err_cnt, pkt_ok_cnt} !== {16'd4, 16'd1}) begin
            errors++; $display("FAIL align_loss_cnt got err=%0d ok=%0d want 4/1",
                               pkt_err_cnt, pkt_ok_cnt);
        end
        checks++;
        if ({rx_busy_led, rx_fail_led, ctl_rx_enable} !== 3'b011) begin
            errors++; $display("FAIL align_loss_state got busy/fail/ctl=%b want 011",
                               {rx_busy_led, rx_fail_led, ctl_rx_enable});
        end
        step();
        step();
        stat_rx_aligned = 1'b1;
        step();
        checks++;
        if (rx_busy_led !== 1'b1) begin
            errors++; $display("FAIL realign_busy got %b want 1", rx_busy_led);
        end
        send_frame(8'd5, 522, 64'd0, 1'b0, -1);
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt, byte_cnt} !== {16'd2, 16'd4, 32'd1044}) begin
            errors++; $display("FAIL resume got ok=%0d err=%0d bytes=%0d want 2/4/1044",
                               pkt_ok_cnt, pkt_err_cnt, byte_cnt);
        end
    endtask

    task automatic test_timeout();
        do_restart();
        for (int i = 0; i < 10; i++) send_frame(8'(i), 522, 64'd0, 1'b0, -1);
        for (int i = 0; i < 99; i++) step();
        checks++;
        if ({rx_done_led, rx_fail_led} !== 2'b00) begin
            errors++; $display("FAIL timeout_early got done/fail=%b want 00",
                               {rx_done_led, rx_fail_led});
        end
        step();
        checks++;
        if ({rx_done_led, rx_fail_led} !== 2'b11) begin
            errors++; $display("FAIL timeout got done/fail=%b want 11",
                               {rx_done_led, rx_fail_led});
        end
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt} !== {16'd10, 16'd0}) begin
            errors++; $display("FAIL timeout_cnt got ok=%0d err=%0d want 10/0",
                               pkt_ok_cnt, pkt_err_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        do_restart();
        send_frame(8'd0, 522, 64'd0, 1'b0, -1);
        checks++;
        if (pkt_ok_cnt !== 16'd1) begin
            errors++; $display("FAIL pre_reset_ok got %0d want 1", pkt_ok_cnt);
        end
        for (int b = 0; b < 3; b++) drive_beat(8'd1, b, '1, 1'b0, 1'b0, -1);
        aresetn = 1'b0;
        idle_bus();
        #1;
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt, byte_cnt} !== 64'd0) begin
            errors++; $display("FAIL midreset_cnt got %0d/%0d/%0d want 0/0/0",
                               pkt_ok_cnt, pkt_err_cnt, byte_cnt);
        end
        checks++;
        if ({ctl_rx_enable, rx_aligned_led, rx_busy_led, rx_done_led, rx_fail_led} !== 5'b0) begin
            errors++; $display("FAIL midreset_leds got %b want 00000",
                               {ctl_rx_enable, rx_aligned_led, rx_busy_led, rx_done_led,
                                rx_fail_led});
        end
        step();
        aresetn = 1'b1;
        step();
        step();
        send_frame(8'd0, 522, 64'd0, 1'b0, -1);
        checks++;
        if ({pkt_ok_cnt, pkt_err_cnt, byte_cnt} !== {16'd1, 16'd0, 32'd522}) begin
            errors++; $display("FAIL post_reset got ok=%0d err=%0d bytes=%0d want 1/0/522",
                               pkt_ok_cnt, pkt_err_cnt, byte_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_align();
        test_full_run(-1);
        test_restart();
        test_full_run(5);
        do_restart();
        test_bad_frames();
        test_align_loss();
        test_timeout();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
